// File: rtl/lu_pipe.sv
// Two-stage valid/ready logic unit: out[i] = sel[{A[i],B[i]}], with registered zero flag.
// Optional registered parity flag enabled by defining LU_PIPE_PARITY_EN.
module lu_pipe #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             zero,
    output logic             parity
);

    logic             s1_valid;
    logic             s2_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic [3:0]       s1_sel;
    logic             s2_free;
    logic             s1_load;
    logic             s2_load;
    logic [WIDTH-1:0] result;

    // Handshake: S2 frees when empty or draining; S1 may refill whenever it can move on.
    assign s2_free   = ~s2_valid | out_ready;
    assign in_ready  = ~s1_valid | s2_free;
    assign s1_load   = in_valid & in_ready;
    assign s2_load   = s1_valid & s2_free;
    assign out_valid = s2_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
        end else if (s1_load) begin
            s1_valid <= 1'b1;
        end else if (s2_load) begin
            s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid <= 1'b0;
        end else if (s2_load) begin
            s2_valid <= 1'b1;
        end else if (out_ready) begin
            s2_valid <= 1'b0;
        end
    end

    // Operand register: loads only on acceptance so stalls cause no toggles.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_a   <= '0;
            s1_b   <= '0;
            s1_sel <= 4'b0000;
        end else if (s1_load) begin
            s1_a   <= A;
            s1_b   <= B;
            s1_sel <= sel;
        end
    end

    // Truth-table lookup per bit.
    always_comb begin
        result = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            result[i] = s1_sel[{s1_a[i], s1_b[i]}];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out  <= '0;
            zero <= 1'b1;
        end else if (s2_load) begin
            out  <= result;
            zero <= (result == '0);
        end
    end

`ifdef LU_PIPE_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            parity <= 1'b0;
        end else if (s2_load) begin
            parity <= ^result;
        end
    end
`else
    assign parity = 1'b0;
`endif

endmodule

// File: tb/tb_lu_pipe.sv
// Scoreboard bench for lu_pipe: accepted beats push expected results,
// consumed results pop and compare (data, zero, parity, latency).
module tb_lu_pipe;

    localparam int unsigned W = 32;
`ifdef LU_PIPE_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [3:0]   sel;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out;
    logic         zero;
    logic         parity;

    lu_pipe #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .A(a), .B(b), .sel(sel), .out_valid(out_valid), .out_ready(out_ready),
        .out(out), .zero(zero), .parity(parity)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] res;
        logic         zero;
        logic         par;
        int           acc;
    } exp_t;

    exp_t         q[$];
    logic [W-1:0] got_log[$];
    int total = 0;
    int bad = 0;
    int cyc = 0;
    int n_acc = 0;
    int n_pop = 0;
    bit check_lat = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Sum-of-minterms reference model of the truth-table function.
    function automatic logic [W-1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic [3:0] s);
        logic [W-1:0] r;
        r = '0;
        if (s[3]) r = r | (x & y);
        if (s[2]) r = r | (x & ~y);
        if (s[1]) r = r | (~x & y);
        if (s[0]) r = r | (~x & ~y);
        return r;
    endfunction

    // Monitor: sample at the falling edge; the handshakes complete at the next rising edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                q.delete();
            end else begin
                if (out_valid && out_ready) begin
                    n_pop++;
                    got_log.push_back(out);
                    if (q.size() == 0) begin
                        check("unexpected_out", 64'(out), 64'hDEAD);
                    end else begin
                        e = q.pop_front();
                        check("out", 64'(out), 64'(e.res));
                        check("zero", 64'(zero), 64'(e.zero));
                        check("parity", 64'(parity), 64'(e.par));
                        if (check_lat) check("latency", 64'(cyc - e.acc), 64'd2);
                    end
                end
                if (in_valid && in_ready) begin
                    n_acc++;
                    e.res  = model(a, b, sel);
                    e.zero = (e.res == '0);
                    e.par  = PAR_EN ? ^e.res : 1'b0;
                    e.acc  = cyc;
                    q.push_back(e);
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the beat is accepted.
    task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic [3:0] s);
        int n;
        n = 0;
        in_valid = 1'b1;
        a = x;
        b = y;
        sel = s;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("send_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((q.size() != 0 || out_valid) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain", 64'(q.size()), 64'd0);
    endtask

    initial begin
        int c0;
        int base;
        int p0;
        int a0;
        rst = 1'b1;
        in_valid = 1'b1;
        out_ready = 1'b1;
        a = 32'hFFFF_FFFF;
        b = 32'h0;
        sel = 4'b1111;

        // Reset with in_valid high: nothing must be captured.
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_zero", 64'(zero), 64'd1);
        check("rst_out", 64'(out), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_parity", 64'(parity), 64'd0);
        @(posedge clk);
        #1;

        // Function sweep, back to back, latency 2.
        check_lat = 1'b1;
        base = got_log.size();
        c0 = cyc;
        for (int s = 0; s < 16; s++) send(32'hF0F0_F0F0, 32'hFF00_FF00, 4'(s));
        check("sweep_throughput", 64'(cyc - c0), 64'd16);
        wait_drain();
        check("sweep_count", 64'(got_log.size() - base), 64'd16);
        if (got_log.size() >= base + 16) begin
            check("sweep_and", 64'(got_log[base + 8]), 64'hF000_F000);
            check("sweep_xor", 64'(got_log[base + 6]), 64'h0FF0_0FF0);
            check("sweep_nor", 64'(got_log[base + 1]), 64'h000F_000F);
            check("sweep_one", 64'(got_log[base + 15]), 64'hFFFF_FFFF);
            check("sweep_zero", 64'(got_log[base + 0]), 64'h0);
        end
        check_lat = 1'b0;

        // Zero flag.
        base = got_log.size();
        send(32'h1234_5678, 32'h1234_5678, 4'b0110);
        send(32'h1234_5678, 32'h1234_5678, 4'b1001);
        wait_drain();
        if (got_log.size() >= base + 2) begin
            check("zero_xor", 64'(got_log[base]), 64'h0);
            check("zero_xnor", 64'(got_log[base + 1]), 64'hFFFF_FFFF);
        end

        // Parity sample: OR of 0x07 and 0 gives 0x07 (odd parity when enabled).
        send(32'h0000_0007, 32'h0, 4'b1110);
        wait_drain();

        // Backpressure: 5 beats with out_ready low.
        p0 = n_pop;
        a0 = n_acc;
        out_ready = 1'b0;
        fork
            begin
                for (int k = 0; k < 5; k++)
                    send(32'(k) * 32'h0101_0101 + 32'h1357_9BDF, 32'hA5A5_0F0F, 4'(k + 5));
            end
            begin
                repeat (4) @(negedge clk);
                check("bp_accepts", 64'(n_acc - a0), 64'd2);
                check("bp_in_ready", 64'(in_ready), 64'd0);
                check("bp_out_valid", 64'(out_valid), 64'd1);
                if (q.size() > 0) check("bp_hold", 64'(out), 64'(q[0].res));
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        wait_drain();
        check("bp_pops", 64'(n_pop - p0), 64'd5);

        // Random stream with random backpressure.
        p0 = n_pop;
        fork
            begin
                for (int k = 0; k < 40; k++) send(32'($urandom), 32'($urandom), 4'($urandom_range(0, 15)));
            end
            begin
                for (int k = 0; k < 120; k++) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 2) != 0);
                end
                out_ready = 1'b1;
            end
        join
        out_ready = 1'b1;
        wait_drain();
        check("rand_pops", 64'(n_pop - p0), 64'd40);

        // Mid-flight reset discards both beats.
        out_ready = 1'b0;
        send(32'hCAFE_0001, 32'h0, 4'b1100);
        send(32'hCAFE_0002, 32'h0, 4'b1100);
        p0 = n_pop;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("mrst_out_valid", 64'(out_valid), 64'd0);
        check("mrst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        check_lat = 1'b1;
        send(32'h0, 32'h0000_BEEF, 4'b1010);
        repeat (6) @(posedge clk);
        #1;
        check("mrst_pops", 64'(n_pop - p0), 64'd1);
        check("mrst_q", 64'(q.size()), 64'd0);
        check_lat = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
